// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one FIX cycle for sign correction, valid/ready on both sides.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_step;
    state_t              w_state_nxt;
    logic                r_ready;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;
    logic [2:0]          r_op;
    logic                r_neg;
    logic                r_neg_rem;
    logic                r_special;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_opb;
    logic [2*XLEN-1:0]   r_prod;

    logic                w_accept;
    logic                w_sgn_a_op;
    logic                w_sgn_b_op;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_add;
    logic [2*XLEN-1:0]   w_mul_nxt;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_nxt;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign w_accept = valid_i && r_ready && !flush_i;

    // Which operands of the requested op are interpreted as signed
    always_comb begin
        w_sgn_a_op = 1'b0;
        w_sgn_b_op = 1'b0;
        case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sgn_a_op = 1'b1;
                w_sgn_b_op = 1'b1;
            end
            3'b010: begin
                w_sgn_a_op = 1'b1;
                w_sgn_b_op = 1'b0;
            end
            default: begin
                w_sgn_a_op = 1'b0;
                w_sgn_b_op = 1'b0;
            end
        endcase
    end

    assign w_sa    = w_sgn_a_op && operand_a_i[XLEN-1];
    assign w_sb    = w_sgn_b_op && operand_b_i[XLEN-1];
    assign w_mag_a = w_sa ? ({XLEN{1'b0}} - operand_a_i) : operand_a_i;
    assign w_mag_b = w_sb ? ({XLEN{1'b0}} - operand_b_i) : operand_b_i;

    // Divide-by-zero and the single signed-overflow pair resolve without iterating
    assign w_div_zero = op_i[2] && (operand_b_i == {XLEN{1'b0}});
    assign w_ovf      = op_i[2] && !op_i[0]
                        && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                        && (operand_b_i == {XLEN{1'b1}});

    // Result returned for the special cases
    always_comb begin
        w_special_res = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_res = op_i[1] ? operand_a_i : {XLEN{1'b1}};
        end else begin
            w_special_res = op_i[1] ? {XLEN{1'b0}} : operand_a_i;
        end
    end

    // Multiply step: upper half accumulates, whole product shifts right one bit
    assign w_add     = {1'b0, r_prod[2*XLEN-1:XLEN]}
                       + (r_prod[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_add, r_prod[XLEN-1:1]};

    // Divide step: {remainder, quotient} shifts left, trial subtract decides the bit
    assign w_shift   = r_prod[2*XLEN-1:XLEN-1];
    assign w_diff    = w_shift - {1'b0, r_opb};
    assign w_div_nxt = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};

    assign w_prod_fix = r_neg ? ({(2*XLEN){1'b0}} - r_prod) : r_prod;
    assign w_quo      = r_neg ? ({XLEN{1'b0}} - r_prod[XLEN-1:0]) : r_prod[XLEN-1:0];
    assign w_rem      = r_neg_rem ? ({XLEN{1'b0}} - r_prod[2*XLEN-1:XLEN])
                                  : r_prod[2*XLEN-1:XLEN];

    // Result selection in FIX
    always_comb begin
        w_fix_res = {XLEN{1'b0}};
        if (r_special) begin
            w_fix_res = r_prod[XLEN-1:0];
        end else begin
            case (r_op)
                3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         w_fix_res = w_quo;
                3'b110, 3'b111:         w_fix_res = w_rem;
                default:                w_fix_res = {XLEN{1'b0}};
            endcase
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_step = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_step = (w_div_zero || w_ovf) ? ST_FIX : ST_CALC;
                end else begin
                    w_state_step = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_step = ST_FIX;
                end else begin
                    w_state_step = ST_CALC;
                end
            end
            ST_FIX:  w_state_step = ST_DONE;
            ST_DONE: begin
                if (ready_i) begin
                    w_state_step = ST_IDLE;
                end else begin
                    w_state_step = ST_DONE;
                end
            end
            default: w_state_step = ST_IDLE;
        endcase
        w_state_nxt = flush_i ? ST_IDLE : w_state_step;
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op      <= 3'b000;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_special <= 1'b0;
            r_cnt     <= {CW{1'b0}};
            r_opb     <= {XLEN{1'b0}};
            r_prod    <= {(2*XLEN){1'b0}};
            r_result  <= {XLEN{1'b0}};
        end else begin
            if (flush_i) begin
                r_result <= {XLEN{1'b0}};
            end else if (r_state == ST_FIX) begin
                r_result <= w_fix_res;
            end else begin
                r_result <= r_result;
            end

            if (w_accept) begin
                r_op      <= op_i;
                r_neg     <= w_sa ^ w_sb;
                r_neg_rem <= w_sa;
                r_special <= w_div_zero || w_ovf;
                r_cnt     <= {CW{1'b0}};
                r_opb     <= op_i[2] ? w_mag_b : w_mag_a;
                if (w_div_zero || w_ovf) begin
                    r_prod <= {{XLEN{1'b0}}, w_special_res};
                end else begin
                    r_prod <= {{XLEN{1'b0}}, (op_i[2] ? w_mag_a : w_mag_b)};
                end
            end else if (r_state == ST_CALC) begin
                r_prod <= r_op[2] ? w_div_nxt : w_mul_nxt;
                r_cnt  <= (r_cnt == CNT_LAST) ? {CW{1'b0}} : (r_cnt + {{(CW-1){1'b0}}, 1'b1});
            end else begin
                r_prod <= r_prod;
                r_cnt  <= r_cnt;
            end
        end
    end

endmodule
